shift_deserializer_ctrl: RTL and testbench

Serial-to-parallel controller that sequences a DEPTH-bit left-shift register. It accepts a bit stream over a valid/ready handshake and counts bits into the register. Each completed word moves into an output holding register, presented on a valid/ready word interface. It sits between a serial link front-end and any word-oriented consumer, with backpressure in both directions and no data loss.

---
 rtl/shift_deserializer_ctrl.sv | 76 +++++++
 tb/tb_shift_deserializer_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer_ctrl.sv
// Serial-to-parallel controller: shifts an MSB-first bit stream into a DEPTH-bit
// register and hands each completed word to a valid/ready word interface.
module shift_deserializer_ctrl #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_bit,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DEPTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    bit_count,
  output logic [15:0]      word_count
);

  logic [DEPTH-1:0] sr;
  logic             full;
  logic             drain;
  logic             load_ok;
  logic             load;
  logic             accept;

  assign full    = (bit_count == CW'(DEPTH));
  assign drain   = m_valid && m_ready;
  assign load_ok = !m_valid || m_ready;
  assign load    = full && load_ok && !flush;
  // The load cycle also accepts a new bit, so a full sr never stalls the link
  // as long as the holding register can take its word.
  assign s_ready = !reset && !flush && (!full || load_ok);
  assign accept  = s_valid && s_ready;

  // NOTE: every register here is assigned with <= so that all of them sample
  // the pre-edge values of load/accept/drain, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      bit_count  <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      word_count <= '0;
    end else begin
      if (flush) begin
        sr <= '0;
      end else if (accept) begin
        sr <= {sr[DEPTH-2:0], s_bit};
      end

      if (flush) begin
        bit_count <= '0;
      end else if (load && accept) begin
        bit_count <= CW'(1);
      end else if (load) begin
        bit_count <= '0;
      end else if (accept) begin
        bit_count <= bit_count + CW'(1);
      end

      // A drain during flush still completes; only the sr word is discarded.
      if (load) begin
        m_data  <= sr;
        m_valid <= 1'b1;
      end else if (drain) begin
        m_valid <= 1'b0;
      end

      if (drain) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_shift_deserializer_ctrl.sv
// Directed bench for shift_deserializer_ctrl (DEPTH = 8): each task drives one
// scenario and compares outputs against hand-computed values.
module tb_shift_deserializer_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             s_bit;
  logic             s_valid;
  logic             s_ready;
  logic [DEPTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CW-1:0]    bit_count;
  logic [15:0]      word_count;

  int total = 0;
  int bad   = 0;

  shift_deserializer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .s_bit      (s_bit),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .bit_count  (bit_count),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_bit = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives 8 consecutive bits MSB first, one per edge, with s_valid held high.
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      s_valid = 1'b1;
      s_bit   = w[i];
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; s_valid = 1'b1; s_bit = 1'b1; m_ready = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_sready_in_reset got=%b exp=0", s_ready); end
    tick();
    tick();
    reset = 1'b0; s_valid = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_mdata got=%h exp=00", m_data); end
    total++; if (bit_count !== 4'd0) begin bad++; $display("FAIL rst_bitcount got=%0d exp=0", bit_count); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL rst_wordcount got=%0d exp=0", word_count); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_sready_after got=%b exp=1", s_ready); end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    send_word(8'hA5);
    s_valid = 1'b0;
    total++; if (bit_count !== 4'd8) begin bad++; $display("FAIL single_full got=%0d exp=8", bit_count); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", m_valid); end
    tick();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", m_valid); end
    total++; if (m_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", m_data); end
    total++; if (bit_count !== 4'd0) begin bad++; $display("FAIL single_bitcount got=%0d exp=0", bit_count); end
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_len got=%b exp=0", m_valid); end
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL single_wordcount got=%0d exp=1", word_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    int          nvalid;
    int          vcycle [2];
    logic [7:0]  vdata  [2];
    stream = 16'h3CC3;
    nvalid = 0;
    reset_dut();
    m_ready = 1'b1;
    // Cycle c drives bit c-1 before edge c; loads are expected after edges 9 and 17.
    for (int c = 1; c <= 20; c++) begin
      s_valid = (c <= 16);
      s_bit   = (c <= 16) ? stream[16 - c] : 1'b0;
      if (c <= 16) begin
        #0;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_sready cycle=%0d got=%b exp=1", c, s_ready); end
      end
      tick();
      if (m_valid === 1'b1) begin
        if (nvalid < 2) begin
          vcycle[nvalid] = c;
          vdata[nvalid]  = m_data;
        end
        nvalid++;
      end
    end
    total++; if (nvalid != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", nvalid); end
    if (nvalid >= 2) begin
      total++; if (vcycle[0] != 9) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=9", vcycle[0]); end
      total++; if (vcycle[1] != 17) begin bad++; $display("FAIL b2b_second_cycle got=%0d exp=17", vcycle[1]); end
      total++; if (vdata[0] !== 8'h3C) begin bad++; $display("FAIL b2b_first_data got=%h exp=3c", vdata[0]); end
      total++; if (vdata[1] !== 8'hC3) begin bad++; $display("FAIL b2b_second_data got=%h exp=c3", vdata[1]); end
    end
    total++; if (word_count !== 16'd2) begin bad++; $display("FAIL b2b_wordcount got=%0d exp=2", word_count); end
  endtask

  task automatic test_reset_mid();
    // Continues from the back-to-back state so word_count starts non-zero.
    m_ready = 1'b0;
    send_word(8'h55);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_bit   = i[0];
      tick();
    end
    s_valid = 1'b0;
    total++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin bad++; $display("FAIL rmid_held got=%b/%h exp=1/55", m_valid, m_data); end
    total++; if (bit_count !== 4'd5) begin bad++; $display("FAIL rmid_partial got=%0d exp=5", bit_count); end
    total++; if (word_count !== 16'd2) begin bad++; $display("FAIL rmid_wc_before got=%0d exp=2", word_count); end
    reset = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_bit = 1'b1;
    tick();
    reset = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_mvalid got=%b exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rmid_mdata got=%h exp=00", m_data); end
    total++; if (bit_count !== 4'd0) begin bad++; $display("FAIL rmid_bitcount got=%0d exp=0", bit_count); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL rmid_wordcount got=%0d exp=0", word_count); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rmid_sready got=%b exp=1", s_ready); end
  endtask

  task automatic test_stall();
    reset_dut();
    m_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    s_valid = 1'b1; s_bit = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL stall_sready got=%b exp=0", s_ready); end
    total++; if (bit_count !== 4'd8) begin bad++; $display("FAIL stall_bitcount got=%0d exp=8", bit_count); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin bad++; $display("FAIL stall_held got=%b/%h exp=1/11", m_valid, m_data); end
    tick();
    tick();
    total++; if (m_data !== 8'h11 || m_valid !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b/%h exp=1/11", m_valid, m_data); end
    total++; if (bit_count !== 4'd8) begin bad++; $display("FAIL stall_frozen got=%0d exp=8", bit_count); end
    m_ready = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stall_release_sready got=%b exp=1", s_ready); end
    tick();
    m_ready = 1'b0; s_valid = 1'b0;
    total++; if (m_data !== 8'h22 || m_valid !== 1'b1) begin bad++; $display("FAIL stall_new_word got=%b/%h exp=1/22", m_valid, m_data); end
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL stall_wordcount got=%0d exp=1", word_count); end
    total++; if (bit_count !== 4'd1) begin bad++; $display("FAIL stall_next_bit got=%0d exp=1", bit_count); end
  endtask

  task automatic test_flush();
    reset_dut();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_bit = 1'b1;
      tick();
    end
    total++; if (bit_count !== 4'd3) begin bad++; $display("FAIL flush_partial got=%0d exp=3", bit_count); end
    flush = 1'b1; s_valid = 1'b1; s_bit = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL flush_sready got=%b exp=0", s_ready); end
    tick();
    flush = 1'b0;
    total++; if (bit_count !== 4'd0) begin bad++; $display("FAIL flush_bitcount got=%0d exp=0", bit_count); end
    send_word(8'h81);
    s_valid = 1'b0;
    tick();
    total++; if (m_valid !== 1'b1 || m_data !== 8'h81) begin bad++; $display("FAIL flush_clean_word got=%b/%h exp=1/81", m_valid, m_data); end
  endtask

  task automatic test_flush_drain();
    reset_dut();
    m_ready = 1'b0;
    send_word(8'h99);
    send_word(8'hF0);
    s_valid = 1'b0;
    total++; if (m_data !== 8'h99 || bit_count !== 4'd8) begin bad++; $display("FAIL fdrain_setup got=%h/%0d exp=99/8", m_data, bit_count); end
    flush = 1'b1; m_ready = 1'b1;
    tick();
    flush = 1'b0; m_ready = 1'b0;
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL fdrain_wordcount got=%0d exp=1", word_count); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fdrain_mvalid got=%b exp=0", m_valid); end
    total++; if (bit_count !== 4'd0) begin bad++; $display("FAIL fdrain_bitcount got=%0d exp=0", bit_count); end
    total++; if (m_data !== 8'h99) begin bad++; $display("FAIL fdrain_mdata_hold got=%h exp=99", m_data); end
    tick();
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fdrain_discarded got=%b exp=0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    test_flush();
    test_flush_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
